// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward receive buffer behind the MAC: frames are written speculatively
// and only made visible to the read side once they finish clean, long enough and address-matched.
module eth_rx_frame_filter #(
  parameter int ADDR_W    = 11,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] cfg_mac_addr,
  input  logic        cfg_promisc,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] stat_good,
  output logic [31:0] stat_drop_err,
  output logic [31:0] stat_drop_filt,
  output logic [31:0] stat_drop_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state_reg, state_next;
  logic [ADDR_W:0] wr_ptr_cur_reg, wr_ptr_cur_next;
  logic [ADDR_W:0] wr_ptr_com_reg, wr_ptr_com_next;
  logic [ADDR_W:0] rd_ptr_reg;
  logic [2:0]      byte_idx_reg, byte_idx_next;
  logic            match_uc_reg, match_uc_next;
  logic            match_bc_reg, match_bc_next;
  logic [47:0]     mac_lat_reg;
  logic            promisc_lat_reg;

  logic [31:0] stat_good_reg, stat_drop_err_reg, stat_drop_filt_reg, stat_drop_ovf_reg;
  logic        inc_good, inc_err, inc_filt, inc_ovf;
  logic        wr_en, latch_cfg;

  logic [8:0]  mem [DEPTH];
  logic [8:0]  ram_q_reg;
  logic        ram_q_valid_reg;
  logic [7:0]  out_data_reg;
  logic        out_valid_reg, out_last_reg;

  logic        full;
  logic [47:0] mac_sel;
  logic        promisc_sel;
  logic [2:0]  cur_idx;
  logic [7:0]  mac_bytes [6];
  logic [7:0]  mac_byte;
  logic        in_hdr, uc_now, bc_now, long_enough, accept;

  // The first byte of a frame is judged against the live config, later bytes against the latched copy.
  assign mac_sel     = (state_reg == IDLE) ? cfg_mac_addr : mac_lat_reg;
  assign promisc_sel = (state_reg == IDLE) ? cfg_promisc  : promisc_lat_reg;
  assign cur_idx     = (state_reg == IDLE) ? 3'd0 : byte_idx_reg;
  assign full        = (wr_ptr_cur_reg - rd_ptr_reg) == FULL_LEVEL;

  for (genvar gi = 0; gi < 6; gi++) begin : g_mac_byte
    assign mac_bytes[gi] = mac_sel[47-8*gi -: 8];
  end

  always_comb begin
    mac_byte = 8'h00;
    case (cur_idx)
      3'd0:    mac_byte = mac_bytes[0];
      3'd1:    mac_byte = mac_bytes[1];
      3'd2:    mac_byte = mac_bytes[2];
      3'd3:    mac_byte = mac_bytes[3];
      3'd4:    mac_byte = mac_bytes[4];
      3'd5:    mac_byte = mac_bytes[5];
      default: mac_byte = 8'h00;
    endcase
  end

  assign in_hdr      = (cur_idx <= 3'd5);
  assign uc_now      = ((state_reg == IDLE) || match_uc_reg) && (!in_hdr || (s_axis_tdata == mac_byte));
  assign bc_now      = ((state_reg == IDLE) || match_bc_reg) && (!in_hdr || (s_axis_tdata == 8'hFF));
  assign long_enough = (cur_idx >= 3'd5);
  assign accept      = !FILTER_EN || promisc_sel || uc_now || bc_now;

  always_comb begin
    state_next      = state_reg;
    wr_ptr_cur_next = wr_ptr_cur_reg;
    wr_ptr_com_next = wr_ptr_com_reg;
    byte_idx_next   = byte_idx_reg;
    match_uc_next   = match_uc_reg;
    match_bc_next   = match_bc_reg;
    wr_en           = 1'b0;
    latch_cfg       = 1'b0;
    inc_good        = 1'b0;
    inc_err         = 1'b0;
    inc_filt        = 1'b0;
    inc_ovf         = 1'b0;
    case (state_reg)
      IDLE, RECV: begin
        if (s_axis_tvalid) begin
          latch_cfg = (state_reg == IDLE);
          if (full) begin
            wr_ptr_cur_next = wr_ptr_com_reg;
            if (s_axis_tlast) begin
              inc_ovf    = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = DROP;
            end
          end else begin
            wr_en           = 1'b1;
            wr_ptr_cur_next = wr_ptr_cur_reg + 1'b1;
            byte_idx_next   = (cur_idx == 3'd6) ? 3'd6 : cur_idx + 3'd1;
            match_uc_next   = uc_now;
            match_bc_next   = bc_now;
            state_next      = RECV;
            if (s_axis_tlast) begin
              state_next = IDLE;
              if (!s_axis_tuser && long_enough && accept) begin
                wr_ptr_com_next = wr_ptr_cur_reg + 1'b1;
                inc_good        = 1'b1;
              end else begin
                wr_ptr_cur_next = wr_ptr_com_reg;
                if (s_axis_tuser || !long_enough) inc_err  = 1'b1;
                else                              inc_filt = 1'b1;
              end
            end
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          inc_ovf    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wr_ptr_cur_reg  <= '0;
      wr_ptr_com_reg  <= '0;
      byte_idx_reg    <= '0;
      match_uc_reg    <= 1'b0;
      match_bc_reg    <= 1'b0;
      mac_lat_reg     <= '0;
      promisc_lat_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_cur_reg <= wr_ptr_cur_next;
      wr_ptr_com_reg <= wr_ptr_com_next;
      byte_idx_reg   <= byte_idx_next;
      match_uc_reg   <= match_uc_next;
      match_bc_reg   <= match_bc_next;
      if (latch_cfg) begin
        mac_lat_reg     <= cfg_mac_addr;
        promisc_lat_reg <= cfg_promisc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_reg      <= '0;
      stat_drop_err_reg  <= '0;
      stat_drop_filt_reg <= '0;
      stat_drop_ovf_reg  <= '0;
    end else begin
      if (inc_good) stat_good_reg      <= stat_good_reg + 32'd1;
      if (inc_err)  stat_drop_err_reg  <= stat_drop_err_reg + 32'd1;
      if (inc_filt) stat_drop_filt_reg <= stat_drop_filt_reg + 32'd1;
      if (inc_ovf)  stat_drop_ovf_reg  <= stat_drop_ovf_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_cur_reg[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Two-stage read: RAM output register, then the AXI-S output register; either can hold under backpressure.
  logic avail, out_ready, s1_move, rd_issue;
  assign avail     = (rd_ptr_reg != wr_ptr_com_reg);
  assign out_ready = !out_valid_reg || m_axis_tready;
  assign s1_move   = ram_q_valid_reg && out_ready;
  assign rd_issue  = avail && (!ram_q_valid_reg || s1_move);

  always_ff @(posedge clk) begin
    if (rd_issue) ram_q_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg      <= '0;
      ram_q_valid_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      ram_q_valid_reg <= rd_issue || (ram_q_valid_reg && !s1_move);
      if (out_ready) begin
        out_valid_reg <= ram_q_valid_reg;
        if (ram_q_valid_reg) begin
          out_last_reg <= ram_q_reg[8];
          out_data_reg <= ram_q_reg[7:0];
        end
      end
    end
  end

  assign m_axis_tdata   = out_data_reg;
  assign m_axis_tvalid  = out_valid_reg;
  assign m_axis_tlast   = out_last_reg;
  assign stat_good      = stat_good_reg;
  assign stat_drop_err  = stat_drop_err_reg;
  assign stat_drop_filt = stat_drop_filt_reg;
  assign stat_drop_ovf  = stat_drop_ovf_reg;

endmodule
